pipelined_array_multiplier: RTL and testbench
=============================================

PIPELINED_ARRAY_MULTIPLIER -- requirements
Module: pipelined_array_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: operand-valid strobe, accepted only when ready=1.
REQ-005 The block SHALL have port is_signed, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 The block SHALL have port a, input, WIDTH bits: multiplicand, sampled with start.
REQ-007 The block SHALL have port b, input, WIDTH bits: multiplier, sampled with start.
REQ-008 The block SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking p valid and newly updated.
REQ-010 The block SHALL have port p, output, 2*WIDTH bits: registered product, held until the next update.

Function
REQ-011 The block SHALL implement FSM states IDLE, CALC and DONE.
REQ-012 In IDLE with start=1 at an edge E0, the block SHALL enter CALC and latch the magnitudes |a| and |b|, the sign flag (is_signed & (a[MSB]^b[MSB])), and bit counter cnt=0.
- |x| = x when is_signed=0; two's-complement negate when is_signed=1 and x[MSB]=1.
REQ-013 On each CALC edge the block SHALL add the shifted multiplicand into a 2*WIDTH-bit accumulator if the current multiplier bit is 1, shift, and increment cnt.
- One row of the array per cycle.
REQ-014 On the WIDTH-th CALC edge (E_WIDTH) the block SHALL enter DONE and load p with the accumulator, negated modulo 2^(2*WIDTH) if the sign flag is set.
REQ-015 done SHALL equal 1 exactly while in DONE (one cycle, E_WIDTH to E_WIDTH+1); the next edge SHALL return the FSM to IDLE unconditionally.
- Fixed latency: done asserted WIDTH edges after the start edge.
REQ-016 ready SHALL be 1 only in IDLE; start SHALL be ignored in CALC and DONE, with no queuing and no corruption of the operation in flight.
REQ-017 Back-to-back throughput SHALL be one product per WIDTH+2 cycles (start re-accepted at edge E_WIDTH+2 at the earliest).
REQ-018 Signed overflow case (-2^(WIDTH-1))*(-2^(WIDTH-1)) SHALL yield +2^(2*WIDTH-2) exactly.
- Magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits.
REQ-019 A zero operand SHALL yield p=0 even when the sign flag is set, with no negative zero.
REQ-020 p SHALL change only on the DONE-entry edge or on reset.
REQ-021 a, b and is_signed changing after the start edge SHALL NOT affect the result.

Reset
REQ-022 While rst=1, regardless of clk, the block SHALL force the FSM to IDLE, with p=0, done=0, ready=1, and accumulator and counter cleared.
REQ-023 Reset asserted mid-CALC SHALL abort the operation with no done pulse, and p SHALL remain 0 after release.
REQ-024 The first start after rst deassertion SHALL be accepted at the first rising edge where rst=0.

Verification (WIDTH=8)
REQ-025 The bench SHALL cover: unsigned a=13, b=11, start one cycle -> done pulse 8 edges later, p=16'h008F, ready low for 9 cycles.
REQ-026 The bench SHALL cover: unsigned a=255, b=255 -> p=16'hFE01; signed a=8'hFD (-3), b=5 -> p=16'hFFF1.
REQ-027 The bench SHALL cover: signed a=8'h80, b=8'h80 -> p=16'h4000; signed a=0, b=8'hFF -> p=16'h0000.
REQ-028 The bench SHALL cover: start with a=7, b=6, then start with a=9, b=9 pulsed during CALC -> p=16'h002A, exactly one done pulse, second request dropped.
REQ-029 The bench SHALL cover: rst asserted 3 edges into CALC, asynchronously between edges -> ready=1, done=0, p=0 immediately, and no done pulse afterwards.
REQ-030 The bench SHALL cover a random regression of 10,000 operands, both modes, including back-to-back starts at the earliest legal edge -> p matches a reference a*b with the correct sign.

Source files
------------

// File: rtl/pipelined_array_multiplier.sv
// ---------------------------------------------------------------------------
// pipelined_array_multiplier
// Sequential shift-add multiplier: one array row per cycle, signed/unsigned.
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module pipelined_array_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int              CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   C_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_p;

  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [2*WIDTH-1:0]   w_acc_sum;

  // The most negative operand negates to itself, which is already the
  // correct unsigned magnitude 2^(WIDTH-1).
  assign w_abs_a   = (is_signed && a[WIDTH-1]) ? -a : a;
  assign w_abs_b   = (is_signed && b[WIDTH-1]) ? -b : b;
  assign w_accept  = (r_state == IDLE) && start;
  assign w_last    = (r_state == CALC) && (r_cnt == C_LAST);
  assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign p         = r_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    ready        = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) w_state_next = CALC;
      end
      CALC: begin
        if (r_cnt == C_LAST) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_p      <= '0;
    end else if (w_accept) begin
      r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
      r_mplier <= w_abs_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (r_state == CALC) begin
      r_acc    <= w_acc_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + C_ONE;
      // Negating a zero magnitude yields zero, so no negative zero escapes.
      if (w_last) r_p <= r_neg ? -w_acc_sum : w_acc_sum;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipelined_array_multiplier.sv
// Self-checking bench for pipelined_array_multiplier (WIDTH=8): directed table,
// multi-cycle corner sequences and a back-to-back random regression.
`timescale 1ns/1ps
`default_nettype none

module tb_pipelined_array_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ready;
  logic        done;
  logic [15:0] p;

  int errors = 0;
  int checks = 0;

  pipelined_array_multiplier #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done      (done),
    .p         (p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One operation: start at a falling-edge drive, expect done 8 edges later.
  task automatic run_op(input logic s, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [15:0] exp, input string name);
    int lat;
    int rlow;
    bit seen;
    bit pmoved;
    logic [15:0] p0;
    @(negedge clk);
    check({name, " ready_before"}, 32'(ready), 32'd1);
    start = 1'b1; is_signed = s; a = ia; b = ib;
    p0 = p;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); is_signed = 1'($urandom);
    lat = 0; rlow = 0; seen = 1'b0; pmoved = 1'b0;
    while (!seen && lat < 20) begin
      if (!ready) rlow++;
      if (done) seen = 1'b1;
      else begin
        if (p !== p0) pmoved = 1'b1;
        @(posedge clk); #1;
        lat++;
      end
    end
    check({name, " done_seen"}, 32'(seen), 32'd1);
    check({name, " latency"}, 32'(lat), 32'd8);
    check({name, " p"}, 32'(p), 32'(exp));
    check({name, " p_held"}, 32'(pmoved), 32'd0);
    check({name, " ready_low"}, 32'(rlow), 32'd9);
    @(posedge clk); #1;
    check({name, " done_one_cycle"}, 32'(done), 32'd0);
    check({name, " ready_after"}, 32'(ready), 32'd1);
  endtask

  vec_t vecs[12];

  initial begin
    int pulses;
    int lat;
    bit pbad;
    logic [15:0] pcap;
    logic [7:0] ra, rb;
    logic rs;
    logic [15:0] ex;

    vecs[0]  = '{1'b0, 8'd13,  8'd11,  16'h008F, "u13x11"};
    vecs[1]  = '{1'b0, 8'hFF,  8'hFF,  16'hFE01, "u255x255"};
    vecs[2]  = '{1'b1, 8'hFD,  8'h05,  16'hFFF1, "s-3x5"};
    vecs[3]  = '{1'b1, 8'h80,  8'h80,  16'h4000, "s_min_sq"};
    vecs[4]  = '{1'b1, 8'h00,  8'hFF,  16'h0000, "s0xm1"};
    vecs[5]  = '{1'b1, 8'hFF,  8'h00,  16'h0000, "sm1x0"};
    vecs[6]  = '{1'b0, 8'h00,  8'hFF,  16'h0000, "u0x255"};
    vecs[7]  = '{1'b1, 8'h7F,  8'h80,  16'hC080, "s127xm128"};
    vecs[8]  = '{1'b1, 8'hFF,  8'hFF,  16'h0001, "sm1xm1"};
    vecs[9]  = '{1'b0, 8'h80,  8'h02,  16'h0100, "u128x2"};
    vecs[10] = '{1'b1, 8'h80,  8'h01,  16'hFF80, "sm128x1"};
    vecs[11] = '{1'b0, 8'h12,  8'h34,  16'h03A8, "u18x52"};

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    #2;
    check("reset ready", 32'(ready), 32'd1);
    check("reset done", 32'(done), 32'd0);
    check("reset p", 32'(p), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    // Second start pulsed mid-operation must be dropped, not queued.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = 8'd7; b = 8'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    start = 1'b1; is_signed = 1'b1; a = 8'd9; b = 8'd9;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; pcap = '0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done) begin pulses++; pcap = p; end
    end
    check("ignore_start pulses", 32'(pulses), 32'd1);
    check("ignore_start p", 32'(pcap), 32'h002A);

    // Asynchronous reset 3 edges into CALC, asserted between edges.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = 8'd13; b = 8'd11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst ready", 32'(ready), 32'd1);
    check("async_rst done", 32'(done), 32'd0);
    check("async_rst p", 32'(p), 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    pulses = 0; pbad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
      if (p !== 16'h0000) pbad = 1'b1;
    end
    check("post_rst done_pulses", 32'(pulses), 32'd0);
    check("post_rst p_zero", 32'(pbad), 32'd0);

    // Start held through reset release is taken at the first edge with rst=0.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; is_signed = 1'b0; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("first_start accepted", 32'(ready), 32'd0);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("first_start latency", 32'(lat), 32'd8);
    check("first_start p", 32'(p), 32'hFE01);
    @(posedge clk); #1;

    // Random regression, back-to-back at the earliest legal start edge.
    for (int n = 0; n < 5000; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      ex = {{8{rs & ra[7]}}, ra} * {{8{rs & rb[7]}}, rb};
      run_op(rs, ra, rb, ex, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
